// File: rtl/step_seq_scheduler.sv
// Table-driven sequencer for the shared add/mult/special/end units.
// It chains each unit result into the next step and guards every step with a watchdog.
module step_seq_scheduler #(
    parameter int MAX_STEPS = 8,
    parameter int DW        = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_addr,
    input  logic [1:0]      cfg_op,
    input  logic [3:0]      prog_len,
    input  logic            start,
    input  logic [DW-1:0]   data_in,
    output logic            busy,
    output logic [DW-1:0]   data_out,
    output logic            done,
    output logic            err,
    output logic [3:0]      unit_start,
    output logic [DW-1:0]   unit_data_in,
    input  logic [4*DW-1:0] unit_out,
    input  logic [3:0]      unit_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam int         WW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [1:0]    state_r;
    logic [1:0]    op_table_r [MAX_STEPS];
    logic [3:0]    step_r;
    logic [3:0]    len_r;
    logic [WW-1:0] wdog_r;
    logic [DW-1:0] inter_r;
    logic [DW-1:0] data_out_r;
    logic          done_r;
    logic          err_r;
    logic          busy_r;
    logic [3:0]    unit_start_r;

    logic [1:0]    cur_op_s;
    logic          sel_done_s;
    logic [DW-1:0] sel_out_s;
    logic          last_s;
    logic          wdog_exp_s;
    logic          len_ok_s;

    function automatic logic [3:0] op_onehot(input logic [1:0] op);
        logic [3:0] oh;
        case (op)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    assign cur_op_s   = op_table_r[step_r[2:0]];
    assign sel_done_s = unit_done[cur_op_s];
    assign last_s     = ((step_r + 4'd1) == len_r);
    assign wdog_exp_s = (wdog_r == WW'(TIMEOUT - 1));
    assign len_ok_s   = (prog_len != 4'd0) && (prog_len <= 4'(MAX_STEPS));

    // Result mux for the unit selected by the current step
    always_comb begin
        sel_out_s = '0;
        case (cur_op_s)
            2'd0:    sel_out_s = unit_out[0*DW +: DW];
            2'd1:    sel_out_s = unit_out[1*DW +: DW];
            2'd2:    sel_out_s = unit_out[2*DW +: DW];
            2'd3:    sel_out_s = unit_out[3*DW +: DW];
            default: sel_out_s = '0;
        endcase
    end

    // Program table; writes are only taken while idle so a run never sees a change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_STEPS; i++) begin
                op_table_r[i] <= 2'd0;
            end
        end else if (cfg_we && (state_r == S_IDLE)) begin
            op_table_r[cfg_addr] <= cfg_op;
        end else begin
            op_table_r <= op_table_r;
        end
    end

    // Sequencer FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            step_r       <= 4'd0;
            len_r        <= 4'd0;
            wdog_r       <= '0;
            inter_r      <= '0;
            data_out_r   <= '0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            unit_start_r <= 4'b0000;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start && len_ok_s) begin
                        inter_r      <= data_in;
                        len_r        <= prog_len;
                        step_r       <= 4'd0;
                        wdog_r       <= '0;
                        state_r      <= S_ISSUE;
                        busy_r       <= 1'b1;
                        unit_start_r <= op_onehot(op_table_r[3'd0]);
                    end else if (start) begin
                        err_r <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    // A done in the final watchdog cycle still completes the step
                    if (sel_done_s) begin
                        unit_start_r <= 4'b0000;
                        if (last_s) begin
                            data_out_r <= sel_out_s;
                            done_r     <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= S_IDLE;
                        end else begin
                            inter_r <= sel_out_s;
                            step_r  <= step_r + 4'd1;
                            state_r <= S_GAP;
                        end
                    end else if (wdog_exp_s) begin
                        unit_start_r <= 4'b0000;
                        err_r        <= 1'b1;
                        busy_r       <= 1'b0;
                        state_r      <= S_IDLE;
                    end else begin
                        wdog_r <= wdog_r + WW'(1);
                    end
                end
                S_GAP: begin
                    wdog_r       <= '0;
                    state_r      <= S_ISSUE;
                    unit_start_r <= op_onehot(cur_op_s);
                end
                default: begin
                    state_r      <= S_IDLE;
                    busy_r       <= 1'b0;
                    unit_start_r <= 4'b0000;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign data_out     = data_out_r;
    assign done         = done_r;
    assign err          = err_r;
    assign unit_start   = unit_start_r;
    assign unit_data_in = inter_r;

endmodule

// File: tb/tb_step_seq_scheduler.sv
// Directed bench for step_seq_scheduler with behavioural unit models.
// A vector table covers single-unit runs; hand sequences cover the multi-cycle cases.
module tb_step_seq_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [1:0]  cfg_op;
    logic [3:0]  prog_len;
    logic        start;
    logic [7:0]  data_in;
    logic        busy;
    logic [7:0]  data_out;
    logic        done;
    logic        err;
    logic [3:0]  unit_start;
    logic [7:0]  unit_data_in;
    logic [31:0] unit_out;
    logic [3:0]  unit_done;

    logic [7:0]  uout [4];
    logic [3:0]  udone;
    logic [3:0]  inj;
    logic [3:0]  en;
    int          cnt [4];
    int          lat [4] = '{2, 3, 1, 1};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    step_seq_scheduler #(.MAX_STEPS(8), .DW(8), .TIMEOUT(10)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_op(cfg_op),
        .prog_len(prog_len), .start(start), .data_in(data_in), .busy(busy),
        .data_out(data_out), .done(done), .err(err), .unit_start(unit_start),
        .unit_data_in(unit_data_in), .unit_out(unit_out), .unit_done(unit_done)
    );

    assign unit_out  = {uout[3], uout[2], uout[1], uout[0]};
    assign unit_done = udone | inj;

    function automatic logic [7:0] unit_fn(input int i, input logic [7:0] x);
        case (i)
            0:       return x + 8'd1;
            1:       return {x[6:0], 1'b0};
            2:       return x ^ 8'h55;
            default: return x;
        endcase
    endfunction

    // Unit models: done pulses lat[i] cycles after start is first seen high
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            udone <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt[i]  <= 0;
                uout[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (udone[i]) begin
                    udone[i] <= 1'b0;
                    cnt[i]   <= 0;
                end else if (unit_start[i] && en[i]) begin
                    if (cnt[i] + 1 == lat[i]) begin
                        udone[i] <= 1'b1;
                        uout[i]  <= unit_fn(i, unit_data_in);
                    end else begin
                        cnt[i] <= cnt[i] + 1;
                    end
                end else begin
                    cnt[i] <= 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int addr, input logic [1:0] op);
        cfg_we   = 1'b1;
        cfg_addr = addr[2:0];
        cfg_op   = op;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic run_start(input logic [7:0] din, input logic [3:0] len);
        start    = 1'b1;
        data_in  = din;
        prog_len = len;
        tick();
        start    = 1'b0;
    endtask

    // Caller sits at cycle c0 after the start edge; returns the cycle of done/err
    task automatic wait_result(input int c0, output logic d, output logic e, output int c);
        c = c0;
        d = 1'b0;
        e = 1'b0;
        while (!(done || err) && (c < c0 + 100)) begin
            tick();
            c++;
        end
        if (done || err) begin
            d = done;
            e = err;
        end else begin
            checks++;
            errors++;
            $display("FAIL wait_result: no done or err within 100 cycles");
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] len;
        logic [7:0] din;
        logic       exp_err;
        logic [7:0] exp_out;
        int         exp_lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic d, e;
        int   c;
        int   gaps, dones, sp_rises;
        logic sp_prev;
        logic [1:0] prog5 [5];

        vecs[0] = '{2'd0, 4'd1, 8'h10, 1'b0, 8'h11, 4};
        vecs[1] = '{2'd1, 4'd1, 8'h81, 1'b0, 8'h02, 5};
        vecs[2] = '{2'd2, 4'd1, 8'hAA, 1'b0, 8'hFF, 3};
        vecs[3] = '{2'd3, 4'd1, 8'hA5, 1'b0, 8'hA5, 3};
        vecs[4] = '{2'd0, 4'd3, 8'hFE, 1'b0, 8'h01, 12};
        vecs[5] = '{2'd1, 4'd2, 8'h03, 1'b0, 8'h0C, 10};
        vecs[6] = '{2'd2, 4'd2, 8'h12, 1'b0, 8'h12, 6};
        vecs[7] = '{2'd0, 4'd0, 8'h77, 1'b1, 8'h12, 1};
        vecs[8] = '{2'd0, 4'd9, 8'h77, 1'b1, 8'h12, 1};
        vecs[9] = '{2'd0, 4'd8, 8'h00, 1'b0, 8'h08, 32};
        prog5   = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_op = 2'd0;
        prog_len = 4'd0; start = 1'b0; data_in = 8'h00; inj = 4'b0000; en = 4'b1111;
        tick();
        tick();
        check("reset_outputs", {busy, done, err, unit_start, data_out, unit_data_in}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", {busy, done, err, unit_start}, 32'h0);

        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < 8; k++) write_entry(k, vecs[v].op);
            run_start(vecs[v].din, vecs[v].len);
            check($sformatf("v%0d_busy", v), busy, !vecs[v].exp_err);
            wait_result(1, d, e, c);
            check($sformatf("v%0d_err", v), e, vecs[v].exp_err);
            check($sformatf("v%0d_done", v), d, !vecs[v].exp_err);
            check($sformatf("v%0d_latency", v), c, vecs[v].exp_lat);
            check($sformatf("v%0d_data_out", v), data_out, vecs[v].exp_out);
            tick();
            check($sformatf("v%0d_pulse", v), {done, err, busy}, 32'h0);
        end

        // Five-step program with a repeated special unit
        for (int k = 0; k < 5; k++) write_entry(k, prog5[k]);
        run_start(8'h10, 4'd5);
        gaps = 0; dones = 0; sp_rises = 0; sp_prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy && unit_start == 4'b0000) gaps++;
            if (done) dones++;
            if (unit_start[2] && !sp_prev) sp_rises++;
            sp_prev = unit_start[2];
            tick();
        end
        check("prog5_data_out", data_out, 8'h22);
        check("prog5_done_count", dones, 1);
        check("prog5_gap_cycles", gaps, 4);
        check("prog5_special_rises", sp_rises, 2);

        // Spurious done on an unselected unit and a table write mid-run
        write_entry(0, 2'd0);
        write_entry(1, 2'd0);
        run_start(8'h30, 4'd2);
        inj = 4'b0100; cfg_we = 1'b1; cfg_addr = 3'd1; cfg_op = 2'd1;
        tick();
        inj = 4'b0000; cfg_we = 1'b0;
        wait_result(2, d, e, c);
        check("spurious_done", d, 1'b1);
        check("spurious_latency", c, 8);
        check("spurious_data_out", data_out, 8'h32);
        tick();
        run_start(8'h30, 4'd2);
        wait_result(1, d, e, c);
        check("dropped_write_data_out", data_out, 8'h32);
        tick();

        // Watchdog abort on a unit that never answers
        write_entry(0, 2'd1);
        en = 4'b1101;
        run_start(8'h07, 4'd1);
        wait_result(1, d, e, c);
        check("timeout_err", {d, e}, 2'b01);
        check("timeout_cycle", c, 11);
        check("timeout_unit_start", unit_start, 4'b0000);
        check("timeout_data_out_kept", data_out, 8'h32);
        check("timeout_busy", busy, 1'b0);
        en = 4'b1111;
        tick();
        run_start(8'h07, 4'd1);
        wait_result(1, d, e, c);
        check("after_timeout_data_out", data_out, 8'h0E);
        check("after_timeout_latency", c, 5);
        tick();

        // Reset asserted while step 3 is in flight
        for (int k = 0; k < 5; k++) write_entry(k, prog5[k]);
        run_start(8'h10, 4'd5);
        repeat (9) tick();
        check("midrun_step3_start", unit_start, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", {busy, done, err, unit_start, data_out, unit_data_in}, 32'h0);
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || err) dones++;
            tick();
        end
        check("midrun_no_done_err", dones, 0);
        run_start(8'h40, 4'd1);
        wait_result(1, d, e, c);
        check("table_cleared_add", data_out, 8'h41);
        tick();
        for (int k = 0; k < 5; k++) write_entry(k, prog5[k]);
        run_start(8'h10, 4'd5);
        wait_result(1, d, e, c);
        check("rerun_data_out", data_out, 8'h22);
        check("rerun_latency", c, 18);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_seq_scheduler.md
# step_seq_scheduler

Programmable sequencer that drives the four shared compute units (add, mult, special, end) in any order of up to MAX_STEPS steps, with any unit reused any number of times. It generalises the fixed add→mult→special→special→end controller into a table-driven scheduler.
- Software loads a per-step opcode table, then issues start with an operand.
- The block chains each unit's result into the next step and returns the final result with a one-cycle done pulse.
- A per-step watchdog aborts hung units.

## Interface
Parameters:
- MAX_STEPS, 8: program table depth (entries 0..MAX_STEPS-1).
- DW, 8: datapath width.
- TIMEOUT, 255: maximum cycles a step may wait for its unit's done before abort.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  table write strobe; ignored while busy=1.
- cfg_addr  in  3  table entry to write.
- cfg_op  in  2  opcode to write: 0=add, 1=mult, 2=special, 3=end.
- prog_len  in  4  number of steps to run; sampled with start.
- start  in  1  run request; honoured only in IDLE.
- data_in  in  DW  operand; sampled with start.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- data_out  out  DW  final result; holds its value until the next successful run.
- done  out  1  one-cycle pulse when the result is valid.
- err  out  1  one-cycle pulse on a rejected start or a timeout abort.
- unit_start  out  4  one-hot unit start, bit i = opcode i; held high while waiting.
- unit_data_in  out  DW  operand broadcast to all units (intermediate register).
- unit_out  in  4*DW  unit results; unit i occupies bits [i*DW +: DW].
- unit_done  in  4  per-unit done pulses.

## Operation
- Reset values: data_out=0, done=0, err=0, busy=0, unit_start=0, every table entry=0 (add), intermediate register=0, state=IDLE.
- Table write: when cfg_we=1 and the block is in IDLE, entry cfg_addr ← cfg_op on the clock edge. A write is visible to a start in the following cycle.
- States: IDLE, ISSUE, GAP.
- IDLE:
  - start with prog_len=0 or prog_len>MAX_STEPS: err pulses next cycle; the block stays in IDLE.
  - start with a valid prog_len: the block latches data_in into the intermediate register, latches prog_len, clears step index and watchdog, and enters ISSUE.
- ISSUE:
  - unit_start[op[step]] is high; all other start bits are low. The watchdog increments each cycle.
  - Done of the selected unit, non-final step: intermediate ← unit_out[op]; step index +1; go to GAP.
  - Done of the selected unit, final step (step index = len-1): data_out ← unit_out[op]; done pulses; go to IDLE.
  - Watchdog reaches TIMEOUT with no done: err pulses; go to IDLE. data_out and done are unaffected.
- GAP: exactly one cycle with all unit_start bits low. This separates back-to-back uses of the same unit so a stale done or output is never captured. Then go to ISSUE and clear the watchdog.
- unit_done bits from non-selected units, and any unit_done in IDLE or GAP, are ignored.
- start while busy is ignored with no error.
- cfg_we while busy is dropped; the running program is unchanged.
- Arithmetic is performed entirely in the units. The block only moves DW-bit values, with no width change.

## Timing
- Accepted start sampled at edge 0: ISSUE and unit_start are high from cycle 1, and busy is high from cycle 1.
- Selected unit_done high in cycle N: for a non-final step, GAP is in cycle N+1 and the next unit_start is high in cycle N+2.
- For the final step, data_out is updated and done=1 in cycle N+1, busy=0 in cycle N+1, and a new start is accepted in cycle N+1.
- Total latency = Σ(unit response cycles) + (len−1) GAP cycles + 1.
- Watchdog: with no done, err=1 at cycle TIMEOUT+1 after ISSUE entry, and unit_start drops in that same cycle.
- Simultaneous done and timeout: done wins and the step completes normally.
- rst_n asserted mid-run: all outputs return to reset values immediately, the table is cleared, and no done or err is produced.

## Test plan
Bench unit models: add out=in+1 (2 cycles); mult out=in*2 mod 256 (3 cycles); special out=in^0x55 (1 cycle); end out=in (1 cycle).
- Program {0,1,2,2,3}, len=5, data_in=0x10 → data_out=0x22 and a single done pulse. Four GAP cycles are seen, and special's start goes low for one cycle between its two uses.
- len=1, op=3, data_in=0xA5 → done=1 and data_out=0xA5 exactly 2 cycles after unit_start rises (1-cycle unit).
- start with len=0, then with len=9 → err pulse each time; busy stays 0 and data_out is unchanged.
- TIMEOUT=10, mult model never answers → err at cycle 11 after ISSUE entry, unit_start=0, no done. A following valid start runs normally.
- Spurious unit_done[2] while waiting on add, plus cfg_we during the run → both ignored; result matches the table as it was before the write.
- rst_n pulsed during step 3 → all outputs are 0 next cycle; a re-run after a table reload gives the correct result.
